// File: rtl/dot_prod_sched_pkg.sv
// Shared types for the CAF dot-product scheduler: FSM state encoding.
package dot_prod_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        DRAIN  = 3'd2,
        HOLD   = 3'd3,
        FINISH = 3'd4
    } sched_state_t;

endpackage

// File: rtl/dot_prod_addr_gen.sv
// Sample/shift counters, wrapped read addresses and the read-latency valid delay line.
module dot_prod_addr_gen #(
    parameter int unsigned LENGTH              = 5,
    parameter int unsigned LENGTH_COUNTER_BITS = 3,
    parameter int unsigned SHIFT_BITS          = 2,
    parameter int unsigned ADDR_BITS           = 10,
    parameter int unsigned READ_LATENCY        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic                  next_shift,
    output logic                  last_c,
    output logic [SHIFT_BITS-1:0] shift,
    output logic                  rd_en,
    output logic [ADDR_BITS-1:0]  ref_addr,
    output logic [ADDR_BITS-1:0]  rx_addr,
    output logic                  x_tvalid,
    output logic                  y_tvalid
);

    localparam int unsigned CNT_W = LENGTH_COUNTER_BITS + 1;

    logic [CNT_W-1:0]        n;
    logic [READ_LATENCY-1:0] vld_pipe;

    assign last_c = (n == CNT_W'(LENGTH - 1));

    // Received address wraps modulo the buffer size.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n        <= '0;
            shift    <= '0;
            rd_en    <= 1'b0;
            ref_addr <= '0;
            rx_addr  <= '0;
        end else begin
            rd_en <= step;
            if (load) begin
                n     <= '0;
                shift <= '0;
            end else if (next_shift) begin
                n     <= '0;
                shift <= shift + SHIFT_BITS'(1);
            end else if (step) begin
                ref_addr <= ADDR_BITS'(n);
                rx_addr  <= ADDR_BITS'(n) + ADDR_BITS'(shift);
                n        <= n + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_en;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
            end
        end
    end

    assign x_tvalid = vld_pipe[READ_LATENCY-1];
    assign y_tvalid = vld_pipe[READ_LATENCY-1];

endmodule

// File: rtl/dot_prod_sched.sv
// Sequences one dot_prod_pip across lag shifts and hands each product downstream tagged by shift.
module dot_prod_sched
    import dot_prod_sched_pkg::*;
#(
    parameter int unsigned LENGTH              = 5,
    parameter int unsigned LENGTH_COUNTER_BITS = 3,
    parameter int unsigned NUM_SHIFTS          = 4,
    parameter int unsigned SHIFT_BITS          = 2,
    parameter int unsigned ADDR_BITS           = 10,
    parameter int unsigned READ_LATENCY        = 1,
    parameter int unsigned I_BITS              = 24,
    parameter int unsigned Q_BITS              = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ADDR_BITS-1:0]  ref_addr,
    output logic [ADDR_BITS-1:0]  rx_addr,
    output logic                  dp_x_tvalid,
    output logic                  dp_y_tvalid,
    output logic                  dp_tready,
    input  logic                  dp_tvalid,
    input  logic [I_BITS-1:0]     dp_i,
    input  logic [Q_BITS-1:0]     dp_q,
    input  logic                  m_axis_tready,
    output logic                  s_axis_tvalid,
    output logic [I_BITS-1:0]     i,
    output logic [Q_BITS-1:0]     q,
    output logic [SHIFT_BITS-1:0] shift_idx,
    output logic                  busy,
    output logic                  done
);

    sched_state_t          state;
    logic                  dp_tvalid_q;
    logic [SHIFT_BITS-1:0] shift;
    logic                  last_c;
    logic                  load_c;
    logic                  step_c;
    logic                  next_c;
    logic                  shift_last_c;

    assign shift_last_c = (shift == SHIFT_BITS'(NUM_SHIFTS - 1));
    assign load_c       = (state == IDLE) && start;
    assign step_c       = (state == ISSUE);
    assign next_c       = (state == HOLD) && m_axis_tready && !shift_last_c;
    assign dp_tready    = busy;

    dot_prod_addr_gen #(
        .LENGTH              (LENGTH),
        .LENGTH_COUNTER_BITS (LENGTH_COUNTER_BITS),
        .SHIFT_BITS          (SHIFT_BITS),
        .ADDR_BITS           (ADDR_BITS),
        .READ_LATENCY        (READ_LATENCY)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .step       (step_c),
        .next_shift (next_c),
        .last_c     (last_c),
        .shift      (shift),
        .rd_en      (rd_en),
        .ref_addr   (ref_addr),
        .rx_addr    (rx_addr),
        .x_tvalid   (dp_x_tvalid),
        .y_tvalid   (dp_y_tvalid)
    );

    // Capture only on a rising dp_tvalid so a level left over from the previous product is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dp_tvalid_q   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            s_axis_tvalid <= 1'b0;
            i             <= '0;
            q             <= '0;
            shift_idx     <= '0;
        end else begin
            dp_tvalid_q <= dp_tvalid;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (last_c) state <= DRAIN;
                end
                DRAIN: begin
                    if (dp_tvalid && !dp_tvalid_q) begin
                        i             <= dp_i;
                        q             <= dp_q;
                        shift_idx     <= shift;
                        s_axis_tvalid <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (m_axis_tready) begin
                        s_axis_tvalid <= 1'b0;
                        if (shift_last_c) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_prod_sched.sv
// Scoreboard bench: two scheduler configurations, a behavioural dot-product/buffer model and a decoupled output monitor.
module tb_dot_prod_sched;

    localparam int unsigned LENGTH = 5;
    localparam int unsigned IW     = 24;

    typedef struct packed {
        logic [IW-1:0] i;
        logic [IW-1:0] q;
        logic [7:0]    s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic m_axis_tready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;
    int bp_mode = 0;
    int bp_cnt  = 0;
    int tbl_ref_i[1024];
    int tbl_ref_q[1024];
    int tbl_rx_i[1024];
    int tbl_rx_q[1024];

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Buffer contents: mode 0 is ref=1+0j, rx=addr+0j; mode 1 uses random tables.
    function automatic int ref_i(input int a); return (mode == 0) ? 1 : tbl_ref_i[a]; endfunction
    function automatic int ref_q(input int a); return (mode == 0) ? 0 : tbl_ref_q[a]; endfunction
    function automatic int rx_i(input int a);  return (mode == 0) ? a : tbl_rx_i[a];  endfunction
    function automatic int rx_q(input int a);  return (mode == 0) ? 0 : tbl_rx_q[a];  endfunction

    function automatic exp_t calc(input int ab, input int s);
        int si = 0;
        int sq = 0;
        int x;
        exp_t e;
        for (int n = 0; n < LENGTH; n++) begin
            x = (n + s) % (1 << ab);
            si += ref_i(n) * rx_i(x) - ref_q(n) * rx_q(x);
            sq += ref_i(n) * rx_q(x) + ref_q(n) * rx_i(x);
        end
        e.i = IW'(si);
        e.q = IW'(sq);
        e.s = 8'(s);
        return e;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int unsigned AB = (k == 0) ? 10 : 3;
        localparam int unsigned NS = (k == 0) ? 4 : 6;
        localparam int unsigned SB = (k == 0) ? 2 : 3;
        localparam int unsigned RL = (k == 0) ? 1 : 2;

        logic          rd_en, x_tv, y_tv, dp_tready, s_tvalid, busy, done;
        logic          dp_tvalid;
        logic [AB-1:0] ref_addr, rx_addr;
        logic [IW-1:0] dp_i, dp_q, i_o, q_o;
        logic [SB-1:0] shift_idx;

        dot_prod_sched #(
            .LENGTH(LENGTH), .LENGTH_COUNTER_BITS(3), .NUM_SHIFTS(NS), .SHIFT_BITS(SB),
            .ADDR_BITS(AB), .READ_LATENCY(RL), .I_BITS(IW), .Q_BITS(IW)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .ref_addr(ref_addr), .rx_addr(rx_addr),
            .dp_x_tvalid(x_tv), .dp_y_tvalid(y_tv), .dp_tready(dp_tready), .dp_tvalid(dp_tvalid),
            .dp_i(dp_i), .dp_q(dp_q), .m_axis_tready(m_axis_tready), .s_axis_tvalid(s_tvalid),
            .i(i_o), .q(q_o), .shift_idx(shift_idx), .busy(busy), .done(done)
        );

        exp_t        exp_q[$];
        int          ra_q[$];
        int          xa_q[$];
        int          done_cnt = 0;
        int          res_cnt  = 0;
        int          acc_i, acc_q, cnt, cd, ra, xa;
        int          exp_n = 0;
        int          bidx  = -1;
        bit          pend;
        logic [RL:0] rd_hist;

        // Expectations on accepted start, address checks, and the dot-product model.
        always @(posedge clk) begin
            if (rst) begin
                exp_q.delete(); ra_q.delete(); xa_q.delete();
                acc_i = 0; acc_q = 0; cnt = 0; cd = 0; pend = 0;
                exp_n = 0; bidx = -1; rd_hist = '0;
                dp_tvalid <= 1'b0; dp_i <= '0; dp_q <= '0;
            end else begin
                if (start && !busy)
                    for (int s = 0; s < NS; s++) exp_q.push_back(calc(AB, s));
                rd_hist = {rd_hist[RL-1:0], rd_en};
                if (x_tv || y_tv || rd_hist[RL]) begin
                    check("x_tvalid_delay", x_tv, rd_hist[RL]);
                    check("y_tvalid_delay", y_tv, rd_hist[RL]);
                end
                if (rd_en) begin
                    if (exp_n == 0) bidx++;
                    check("ref_addr", ref_addr, exp_n);
                    check("rx_addr", rx_addr, (exp_n + bidx) % (1 << AB));
                    check("issue_during_hold", s_tvalid, 0);
                    ra_q.push_back(int'(ref_addr));
                    xa_q.push_back(int'(rx_addr));
                    exp_n = (exp_n + 1) % LENGTH;
                end
                if (busy !== 1'b1) begin
                    exp_n = 0;
                    bidx  = -1;
                end
                if (x_tv && y_tv) begin
                    if (cnt == 0) begin
                        dp_tvalid <= 1'b0;
                        acc_i = 0;
                        acc_q = 0;
                    end
                    if (ra_q.size() == 0) begin
                        check("sample_without_read", 1, 0);
                        ra = 0; xa = 0;
                    end else begin
                        ra = ra_q.pop_front();
                        xa = xa_q.pop_front();
                    end
                    acc_i += ref_i(ra) * rx_i(xa) - ref_q(ra) * rx_q(xa);
                    acc_q += ref_i(ra) * rx_q(xa) + ref_q(ra) * rx_i(xa);
                    cnt++;
                    if (cnt == LENGTH) begin
                        cnt  = 0;
                        pend = 1;
                        cd   = int'($urandom_range(1, 4));
                    end
                end else if (pend) begin
                    cd--;
                    if (cd == 0) begin
                        pend = 0;
                        dp_tvalid <= 1'b1;
                        dp_i <= IW'(acc_i);
                        dp_q <= IW'(acc_q);
                    end
                end
            end
        end

        logic [IW-1:0] h_i, h_q;
        logic [SB-1:0] h_s;
        bit            stalled, prev_done;
        exp_t          e;

        // Output monitor: compares each transfer against the scoreboard.
        always @(negedge clk) begin
            if (rst) begin
                stalled   = 0;
                prev_done = 0;
            end else begin
                if (stalled) begin
                    check("hold_valid", s_tvalid, 1);
                    check("hold_i", i_o, h_i);
                    check("hold_q", q_o, h_q);
                    check("hold_shift", shift_idx, h_s);
                end
                if (s_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_i", i_o, e.i);
                        check("result_q", q_o, e.q);
                        check("result_shift", shift_idx, e.s);
                    end
                    res_cnt++;
                end
                stalled = s_tvalid && !m_axis_tready;
                h_i = i_o; h_q = q_o; h_s = shift_idx;
                if (done) begin
                    done_cnt++;
                    check("done_results_left", exp_q.size(), 0);
                    check("done_width", prev_done, 0);
                end
                prev_done = done;
            end
        end

        always @(posedge rst) begin
            #1;
            check("rst_ctrl", {rd_en, x_tv, y_tv, dp_tready, s_tvalid, busy, done}, 0);
            check("rst_addr", {ref_addr, rx_addr}, 0);
            check("rst_iq", {i_o, q_o}, 0);
            check("rst_shift", shift_idx, 0);
        end
    end

    // Downstream ready: always, random, or a 7-cycle stall on shift 1 of the first instance.
    initial forever begin
        @(posedge clk);
        #1;
        case (bp_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ($urandom_range(0, 3) != 0);
            default: begin
                if (g_inst[0].s_tvalid && g_inst[0].shift_idx == 2'd1 && bp_cnt < 7) begin
                    m_axis_tready = 1'b0;
                    bp_cnt++;
                end else begin
                    m_axis_tready = 1'b1;
                end
            end
        endcase
    end

    task automatic run(input string name, input bit poke_busy);
        int d0 = g_inst[0].done_cnt;
        int d1 = g_inst[1].done_cnt;
        int r0 = g_inst[0].res_cnt;
        int r1 = g_inst[1].res_cnt;
        int c;
        check({name, "_idle0"}, g_inst[0].busy, 0);
        check({name, "_idle1"}, g_inst[1].busy, 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (poke_busy) begin
            c = 0;
            while (g_inst[0].res_cnt < r0 + 2 && c < 2000) begin @(posedge clk); c++; end
            repeat (8) @(posedge clk);
            #1;
            check({name, "_busy0"}, g_inst[0].busy, 1);
            check({name, "_busy1"}, g_inst[1].busy, 1);
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        c = 0;
        while (!(g_inst[0].done_cnt > d0 && g_inst[1].done_cnt > d1) && c < 5000) begin
            @(posedge clk); c++;
        end
        check({name, "_timeout"}, (c < 5000) ? 1 : 0, 1);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_results0"}, g_inst[0].res_cnt - r0, 4);
        check({name, "_results1"}, g_inst[1].res_cnt - r1, 6);
        check({name, "_done0"}, g_inst[0].done_cnt - d0, 1);
        check({name, "_done1"}, g_inst[1].done_cnt - d1, 1);
    endtask

    initial begin
        int c;
        int r0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        mode = 0; bp_mode = 0;
        run("basic", 0);

        bp_mode = 2; bp_cnt = 0;
        run("backpressure", 0);
        check("backpressure_stall_cycles", bp_cnt, 7);

        bp_mode = 0;
        run("start_while_busy", 1);

        mode = 1; bp_mode = 1;
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 1024; a++) begin
                tbl_ref_i[a] = int'($urandom_range(0, 200)) - 100;
                tbl_ref_q[a] = int'($urandom_range(0, 200)) - 100;
                tbl_rx_i[a]  = int'($urandom_range(0, 200)) - 100;
                tbl_rx_q[a]  = int'($urandom_range(0, 200)) - 100;
            end
            run("random", 0);
        end

        // Reset while the first instance issues shift 1, then a fresh run.
        mode = 0; bp_mode = 0;
        r0 = g_inst[0].res_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        c = 0;
        while (g_inst[0].res_cnt < r0 + 1 && c < 2000) begin @(posedge clk); c++; end
        check("midrun_reach_shift1", (c < 2000) ? 1 : 0, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("midrun_busy0", g_inst[0].busy, 0);
        check("midrun_busy1", g_inst[1].busy, 0);
        run("after_reset", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
